// File: rtl/prim_arbiter_burst_pkg.sv
// prim_arbiter_burst_pkg
//   Shared types for the burst-locking round-robin arbiter.
//   arb_burst_state_e : arbiter FSM state (2-bit encoding).
package prim_arbiter_burst_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,  // free to pick a new requester every cycle
      StHold   = 2'b01,  // pick made, first beat stalled by the sink
      StLocked = 2'b10   // burst in progress, grant pinned to sel_q
   } arb_burst_state_e;

endpackage

// File: rtl/prim_rr_pick.sv
// prim_rr_pick
//   Combinational round-robin pick: lowest set index of req_i & mask_i,
//   falling back to the lowest set index of req_i when the masked set is empty.
//   req_i   : request vector
//   mask_i  : priority mask (indices allowed to win first)
//   idx_o   : picked index (0 when nothing is requesting)
//   found_o : at least one request present
module prim_rr_pick
   import prim_arbiter_burst_pkg::*;
#(
   parameter  int N    = 4,
   localparam int IdxW = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [N-1:0]    mask_i,
   output logic [IdxW-1:0] idx_o,
   output logic            found_o
);

   logic [N-1:0]    masked;
   logic [IdxW-1:0] m_idx;
   logic [IdxW-1:0] u_idx;

   always_comb begin
      masked = req_i & mask_i;
      m_idx  = '0;
      u_idx  = '0;
      // Scan downwards so the last write leaves the lowest set index.
      for (int i = N - 1; i >= 0; i--) begin
         if (masked[i]) m_idx = IdxW'(i);
         if (req_i[i])  u_idx = IdxW'(i);
      end
      idx_o   = (|masked) ? m_idx : u_idx;
      found_o = |req_i;
   end

endmodule

// File: rtl/prim_arbiter_burst.sv
// prim_arbiter_burst
//   Round-robin N:1 arbiter that grants whole bursts. After the first beat of
//   a burst is accepted the grant stays with that requester until its last
//   beat is accepted, or until MaxBeats beats have gone through, in which case
//   the burst is cut off and burst_err_o pulses for one cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i, last_i : per-requester beat valid / final-beat flag
//   data_i        : per-requester beat data, requester i at [i*DW +: DW]
//   gnt_o         : one-hot beat accept
//   idx_o         : selected requester
//   valid_o       : selected requester has a beat
//   data_o,last_o : beat of the selected requester
//   ready_i       : sink accepts the beat
//   locked_o      : registered, high while a burst is locked
//   burst_err_o   : registered one-cycle pulse after a burst cutoff
module prim_arbiter_burst
   import prim_arbiter_burst_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int DW       = 32,
   parameter  int MaxBeats = 16,
   localparam int IdxW     = $clog2(N)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N-1:0]    req_i,
   input  logic [N-1:0]    last_i,
   input  logic [N*DW-1:0] data_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o,
   output logic [DW-1:0]   data_o,
   output logic            last_o,
   input  logic            ready_i,
   output logic            locked_o,
   output logic            burst_err_o
);

   localparam int               BeatW  = $clog2(MaxBeats + 1);
   localparam logic [BeatW-1:0] MaxCnt = BeatW'(MaxBeats);

   arb_burst_state_e state_q;
   logic [IdxW-1:0]  sel_q;
   logic [BeatW-1:0] beat_q, beat_d;
   logic [N-1:0]     prio_mask_q, prio_mask_d;
   logic             locked_q, burst_err_q;

   logic [IdxW-1:0]  pick;
   logic             pick_found;
   logic             accept;

   prim_rr_pick #(.N(N)) u_pick (
      .req_i   (req_i),
      .mask_i  (prio_mask_q),
      .idx_o   (pick),
      .found_o (pick_found)
   );

   // Output mux: free pick in StIdle, pinned selection otherwise.
   always_comb begin
      if (state_q == StIdle) begin
         idx_o   = pick;
         valid_o = pick_found;
      end else begin
         idx_o   = sel_q;
         valid_o = req_i[sel_q];
      end
   end

   assign data_o = data_i[idx_o*DW +: DW];
   assign last_o = last_i[idx_o];
   assign accept = valid_o & ready_i;

   always_comb begin
      gnt_o = '0;
      if (accept) gnt_o[idx_o] = 1'b1;
   end

   // Count the beat being accepted now; the first beat of a burst is 1.
   assign beat_d = (state_q == StLocked) ? beat_q + BeatW'(1) : BeatW'(1);

   // On burst completion only indices above the finishing one keep priority,
   // so the next round continues after it and wraps to 0 past N-1.
   always_comb begin
      prio_mask_d = '0;
      for (int i = 0; i < N; i++) begin
         prio_mask_d[i] = (i > int'(idx_o));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         sel_q       <= '0;
         beat_q      <= '0;
         prio_mask_q <= '0;
         locked_q    <= 1'b0;
         burst_err_q <= 1'b0;
      end else begin
         burst_err_q <= 1'b0;
         case (state_q)
            StIdle, StHold, StLocked: begin
               if (accept) begin
                  if (last_o || beat_d == MaxCnt) begin
                     // Burst complete or forcibly released.
                     state_q     <= StIdle;
                     beat_q      <= '0;
                     prio_mask_q <= prio_mask_d;
                     locked_q    <= 1'b0;
                     burst_err_q <= ~last_o;
                  end else begin
                     state_q  <= StLocked;
                     sel_q    <= idx_o;
                     beat_q   <= beat_d;
                     locked_q <= 1'b1;
                  end
               end else if (valid_o && state_q == StIdle) begin
                  // Freeze the pick so idx_o stays stable under backpressure.
                  state_q <= StHold;
                  sel_q   <= idx_o;
               end
            end
            default: begin
               state_q  <= StIdle;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign locked_o    = locked_q;
   assign burst_err_o = burst_err_q;

`ifndef SYNTHESIS
   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(gnt_o));
   a_gnt_ready : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (|gnt_o) |-> ready_i);
   a_idx_stall : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i) |=> $stable(idx_o));
   a_idx_locked : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == StLocked) |=> (state_q != StLocked) || $stable(idx_o));
`endif

endmodule

// File: tb/tb_prim_arbiter_burst.sv
// tb_prim_arbiter_burst
//   Directed scenarios followed by a protocol-respecting random phase, all
//   checked each cycle against a behavioural model of the arbitration rules
//   (owner / beat count / last winner with rotating search order).
module tb_prim_arbiter_burst;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int MB = 4;
   localparam int IW = 2;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic [N-1:0]    req_i = '0;
   logic [N-1:0]    last_i = '0;
   logic [N*DW-1:0] data_i = '0;
   logic            ready_i = 1'b0;
   logic [N-1:0]    gnt_o;
   logic [IW-1:0]   idx_o;
   logic            valid_o;
   logic [DW-1:0]   data_o;
   logic            last_o;
   logic            locked_o;
   logic            burst_err_o;

   always #5 clk_i = ~clk_i;

   prim_arbiter_burst #(.N(N), .DW(DW), .MaxBeats(MB)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (req_i),
      .last_i      (last_i),
      .data_i      (data_i),
      .gnt_o       (gnt_o),
      .idx_o       (idx_o),
      .valid_o     (valid_o),
      .data_o      (data_o),
      .last_o      (last_o),
      .ready_i     (ready_i),
      .locked_o    (locked_o),
      .burst_err_o (burst_err_o)
   );

   int passed = 0;
   int total  = 0;

   // Reference model: owner = requester holding the grant (-1: free),
   // beats = beats already accepted in its burst (0: stalled first beat),
   // lastw = requester that last finished a burst (-1: none since reset).
   int       owner = -1;
   int       beats = 0;
   int       lastw = -1;
   bit       m_err = 1'b0;
   int       e_idx;
   bit       e_valid;
   logic [N-1:0] e_gnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic void predict();
      bit f;
      f       = 1'b0;
      e_idx   = 0;
      e_valid = 1'b0;
      if (owner >= 0) begin
         e_idx   = owner;
         e_valid = req_i[owner];
      end else begin
         for (int i = lastw + 1; i < N; i++)
            if (!f && req_i[i]) begin e_idx = i; f = 1'b1; end
         for (int i = 0; i < N; i++)
            if (!f && req_i[i]) begin e_idx = i; f = 1'b1; end
         e_valid = f;
      end
      e_gnt = (e_valid && ready_i) ? (N'(1) << e_idx) : '0;
   endfunction

   function automatic void model_update();
      int nb;
      m_err = 1'b0;
      if (e_valid && ready_i) begin
         if (last_i[e_idx]) begin
            owner = -1; beats = 0; lastw = e_idx;
         end else begin
            nb = ((owner >= 0) ? beats : 0) + 1;
            if (nb == MB) begin
               owner = -1; beats = 0; lastw = e_idx; m_err = 1'b1;
            end else begin
               owner = e_idx; beats = nb;
            end
         end
      end else if (e_valid && owner < 0) begin
         owner = e_idx; beats = 0;
      end
   endfunction

   function automatic void model_reset();
      owner = -1; beats = 0; lastw = -1; m_err = 1'b0;
   endfunction

   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
      req_i   = r;
      last_i  = l;
      ready_i = rdy;
      for (int i = 0; i < N; i++) data_i[i*DW +: DW] = $urandom();
      #1;
      predict();
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".gnt"},    32'(gnt_o),       32'(e_gnt));
      chk({tag, ".idx"},    32'(idx_o),       32'(e_idx));
      chk({tag, ".valid"},  32'(valid_o),     32'(e_valid));
      chk({tag, ".data"},   32'(data_o),      32'(data_i[e_idx*DW +: DW]));
      chk({tag, ".last"},   32'(last_o),      32'(last_i[e_idx]));
      chk({tag, ".locked"}, 32'(locked_o),    32'(owner >= 0 && beats > 0));
      chk({tag, ".err"},    32'(burst_err_o), 32'(m_err));
   endtask

   task automatic tick();
      model_update();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   logic [N-1:0] rr, ll, g;

   initial begin
      // Reset state
      drive(4'b0000, 4'b0000, 1'b0);
      check_all("reset");
      chk("reset.gnt_c", 32'(gnt_o), 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Single beats after reset
      drive(4'b0110, 4'b0110, 1'b1);
      check_all("single1");
      chk("single1.gnt_c", 32'(gnt_o), 32'h2);
      chk("single1.idx_c", 32'(idx_o), 32'h1);
      tick();
      drive(4'b0100, 4'b0100, 1'b1);
      check_all("single2");
      chk("single2.gnt_c", 32'(gnt_o), 32'h4);
      tick();

      // Locked 3-beat burst from req0 while req1 waits
      drive(4'b0011, 4'b0000, 1'b1);
      check_all("lock1");
      chk("lock1.gnt_c", 32'(gnt_o), 32'h1);
      tick();
      drive(4'b0011, 4'b0000, 1'b1);
      check_all("lock2");
      chk("lock2.gnt_c", 32'(gnt_o), 32'h1);
      chk("lock2.locked_c", 32'(locked_o), 32'h1);
      tick();
      drive(4'b0011, 4'b0001, 1'b1);
      check_all("lock3");
      chk("lock3.gnt_c", 32'(gnt_o), 32'h1);
      chk("lock3.locked_c", 32'(locked_o), 32'h1);
      tick();
      drive(4'b0010, 4'b0010, 1'b1);
      check_all("lock4");
      chk("lock4.gnt_c", 32'(gnt_o), 32'h2);
      chk("lock4.locked_c", 32'(locked_o), 32'h0);
      tick();
      drive(4'b1000, 4'b1000, 1'b1);   // move round-robin pointer past 3
      check_all("wrapprep");
      tick();

      // Hold under backpressure
      for (int k = 0; k < 3; k++) begin
         drive(4'b1001, 4'b1001, 1'b0);
         check_all("hold");
         chk("hold.idx_c", 32'(idx_o), 32'h0);
         chk("hold.gnt_c", 32'(gnt_o), 32'h0);
         tick();
      end
      drive(4'b1001, 4'b1001, 1'b1);
      check_all("holdrel");
      chk("holdrel.gnt_c", 32'(gnt_o), 32'h1);
      tick();
      drive(4'b1000, 4'b1000, 1'b1);
      check_all("holdnext");
      chk("holdnext.gnt_c", 32'(gnt_o), 32'h8);
      tick();

      // Burst cutoff: req2 sends non-last beats, req3 waits
      for (int k = 0; k < MB; k++) begin
         drive(4'b1100, 4'b1000, 1'b1);
         check_all("cut");
         chk("cut.gnt_c", 32'(gnt_o), 32'h4);
         tick();
      end
      drive(4'b1100, 4'b1000, 1'b1);
      check_all("cutrel");
      chk("cutrel.err_c", 32'(burst_err_o), 32'h1);
      chk("cutrel.gnt_c", 32'(gnt_o), 32'h8);
      tick();
      drive(4'b0100, 4'b0000, 1'b1);
      check_all("cut5");
      chk("cut5.err_c", 32'(burst_err_o), 32'h0);
      chk("cut5.gnt_c", 32'(gnt_o), 32'h4);
      tick();
      drive(4'b0100, 4'b0000, 1'b1);
      check_all("cut6");
      tick();
      drive(4'b0100, 4'b0100, 1'b1);
      check_all("cutend");
      tick();
      drive(4'b1000, 4'b1000, 1'b1);
      check_all("fairprep");
      tick();

      // Fairness and wrap-around
      for (int k = 0; k < 5; k++) begin
         drive(4'b1111, 4'b1111, 1'b1);
         check_all("fair");
         chk("fair.gnt_c", 32'(gnt_o), 32'(1 << (k % 4)));
         tick();
      end

      // Reset during beat 2 of a burst
      drive(4'b0010, 4'b0000, 1'b1);
      check_all("rstb1");
      chk("rstb1.gnt_c", 32'(gnt_o), 32'h2);
      tick();
      drive(4'b0010, 4'b0000, 1'b1);
      chk("rstb2.locked_c", 32'(locked_o), 32'h1);
      rst_ni = 1'b0;
      #1;
      chk("rstmid.locked_c", 32'(locked_o), 32'h0);
      chk("rstmid.err_c", 32'(burst_err_o), 32'h0);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      drive(4'b0011, 4'b0011, 1'b1);
      check_all("rstafter");
      chk("rstafter.gnt_c", 32'(gnt_o), 32'h1);
      tick();

      // Random traffic; requesters keep a beat stable until it is granted
      rr = '0;
      ll = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!rr[i] && ($urandom % 3 == 0)) begin
               rr[i] = 1'b1;
               ll[i] = ($urandom % 4 == 0);
            end
         drive(rr, ll, ($urandom % 4) != 0);
         check_all("rand");
         g = e_gnt;
         tick();
         for (int i = 0; i < N; i++)
            if (g[i]) begin
               rr[i] = 1'($urandom % 2);
               ll[i] = ($urandom % 4 == 0);
            end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
